// File: rtl/sramx_memory_pkg.sv
// Shared sramx request/response types, error read data and the byte-lane merge
// used by the memory and the bus converter checkers.
package sramx_memory_pkg;

  typedef struct packed {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sramx_req_t;

  typedef struct packed {
    logic [31:0] rdata;
  } sramx_resp_t;

  localparam logic [31:0] SRAMX_ERR_RDATA = 32'h0000_0000;

  function automatic logic [31:0] sramx_merge(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wen);
    logic [31:0] merged;
    merged = old;
    for (int k = 0; k < 4; k++) begin
      if (wen[k]) begin
        merged[8*k +: 8] = wdata[8*k +: 8];
      end else begin
        merged[8*k +: 8] = old[8*k +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/sramx_memory_bank.sv
// Word storage with one byte-enabled write port and two registered read ports;
// a read of the word being written in the same cycle returns the merged word.
module sramx_bank
  import sramx_memory_pkg::*;
#(
  parameter int MEM_WORDS = 16384
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         i_we,
  input  logic [$clog2(MEM_WORDS)-1:0] i_widx,
  input  logic [31:0]                  i_wdata,
  input  logic [3:0]                   i_wen,
  input  logic                         i_a_re,
  input  logic                         i_a_clr,
  input  logic [$clog2(MEM_WORDS)-1:0] i_a_idx,
  output logic [31:0]                  o_a_rdata,
  input  logic                         i_b_re,
  input  logic                         i_b_clr,
  input  logic [$clog2(MEM_WORDS)-1:0] i_b_idx,
  output logic [31:0]                  o_b_rdata
);

  logic [31:0] r_mem [MEM_WORDS];
  logic [31:0] r_a_rdata;
  logic [31:0] r_b_rdata;
  logic [31:0] w_merged;

  assign w_merged  = sramx_merge(r_mem[i_widx], i_wdata, i_wen);
  assign o_a_rdata = r_a_rdata;
  assign o_b_rdata = r_b_rdata;

  // A write sampled while reset is held low is discarded; contents otherwise persist.
  always_ff @(posedge clk) begin
    if (resetn && i_we) begin
      r_mem[i_widx] <= w_merged;
    end
  end

  // Read port A: hold when idle, zero on out-of-range, forward a same-word write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_a_rdata <= 32'h0000_0000;
    end else if (i_a_re) begin
      if (i_a_clr) begin
        r_a_rdata <= SRAMX_ERR_RDATA;
      end else if (i_we && (i_a_idx == i_widx)) begin
        r_a_rdata <= w_merged;
      end else begin
        r_a_rdata <= r_mem[i_a_idx];
      end
    end
  end

  // Read port B: same behaviour as port A.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_b_rdata <= 32'h0000_0000;
    end else if (i_b_re) begin
      if (i_b_clr) begin
        r_b_rdata <= SRAMX_ERR_RDATA;
      end else if (i_we && (i_b_idx == i_widx)) begin
        r_b_rdata <= w_merged;
      end else begin
        r_b_rdata <= r_mem[i_b_idx];
      end
    end
  end

endmodule

// File: rtl/sramx_memory.sv
// Dual-port sramx responder: instruction port read-only, data port read/write,
// shared coherent storage, sticky out-of-range capture and access counters.
module sramx_memory
  import sramx_memory_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_WORDS = 16384
) (
  input  logic        clk,
  input  logic        resetn,
  input  sramx_req_t  ireq,
  output sramx_resp_t iresp,
  input  sramx_req_t  dreq,
  output sramx_resp_t dresp,
  output logic        bus_err,
  output logic [31:0] err_addr,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int          IDX_W = $clog2(MEM_WORDS);
  localparam logic [32:0] SPAN  = 33'(MEM_WORDS) << 2;

  logic [31:0]      w_i_off;
  logic [31:0]      w_d_off;
  logic             w_i_in;
  logic             w_d_in;
  logic             w_i_oor;
  logic             w_d_oor;
  logic             w_d_wr;
  logic             w_d_rd;
  logic             w_bank_we;
  logic [31:0]      w_rd_inc;
  logic [31:0]      w_wr_inc;
  logic [31:0]      w_i_rdata;
  logic [31:0]      w_d_rdata;
  logic             w_unused;

  logic             r_bus_err;
  logic [31:0]      r_err_addr;
  logic [31:0]      r_rd_count;
  logic [31:0]      r_wr_count;

  // Offsets wrap modulo 2^32, so addresses below BASE_ADDR land far out of range.
  assign w_i_off   = ireq.addr - BASE_ADDR;
  assign w_d_off   = dreq.addr - BASE_ADDR;
  assign w_i_in    = ({1'b0, w_i_off} < SPAN);
  assign w_d_in    = ({1'b0, w_d_off} < SPAN);
  assign w_i_oor   = ireq.en & ~w_i_in;
  assign w_d_oor   = dreq.en & ~w_d_in;
  assign w_d_wr    = dreq.en & (dreq.wen != 4'b0000);
  assign w_d_rd    = dreq.en & (dreq.wen == 4'b0000);
  assign w_bank_we = w_d_wr & w_d_in;
  assign w_unused  = ^{ireq.wen, ireq.wdata};

  assign w_rd_inc  = {31'd0, ireq.en} + {31'd0, w_d_rd};
  assign w_wr_inc  = {31'd0, w_d_wr};

  sramx_bank #(
    .MEM_WORDS (MEM_WORDS)
  ) u_bank (
    .clk       (clk),
    .resetn    (resetn),
    .i_we      (w_bank_we),
    .i_widx    (w_d_off[IDX_W+1:2]),
    .i_wdata   (dreq.wdata),
    .i_wen     (dreq.wen),
    .i_a_re    (ireq.en),
    .i_a_clr   (~w_i_in),
    .i_a_idx   (w_i_off[IDX_W+1:2]),
    .o_a_rdata (w_i_rdata),
    .i_b_re    (dreq.en),
    .i_b_clr   (~w_d_in),
    .i_b_idx   (w_d_off[IDX_W+1:2]),
    .o_b_rdata (w_d_rdata)
  );

  assign iresp.rdata = w_i_rdata;
  assign dresp.rdata = w_d_rdata;
  assign bus_err     = r_bus_err;
  assign err_addr    = r_err_addr;
  assign rd_count    = r_rd_count;
  assign wr_count    = r_wr_count;

  // Sticky error flag; the first faulting address is kept, data port first.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bus_err  <= 1'b0;
      r_err_addr <= 32'h0000_0000;
    end else begin
      if (w_i_oor || w_d_oor) begin
        r_bus_err <= 1'b1;
      end
      if (!r_bus_err) begin
        if (w_d_oor) begin
          r_err_addr <= dreq.addr;
        end else if (w_i_oor) begin
          r_err_addr <= ireq.addr;
        end
      end
    end
  end

  // Access counters, free-running and wrapping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_count <= 32'h0000_0000;
      r_wr_count <= 32'h0000_0000;
    end else begin
      r_rd_count <= r_rd_count + w_rd_inc;
      r_wr_count <= r_wr_count + w_wr_inc;
    end
  end

endmodule

// File: tb/tb_sramx_memory.sv
// Directed-vector bench for sramx_memory with hand-computed expectations.
module tb_sramx_memory;
  import sramx_memory_pkg::*;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          WORDS = 1024;
  localparam logic [31:0] SPANB = 32'(WORDS) * 32'd4;

  logic        clk;
  logic        resetn;
  sramx_req_t  ireq;
  sramx_req_t  dreq;
  sramx_resp_t iresp;
  sramx_resp_t dresp;
  logic        bus_err;
  logic [31:0] err_addr;
  logic [31:0] rd_count;
  logic [31:0] wr_count;

  int          n_vec;
  int          n_err;
  logic [31:0] exp_rd;
  logic [31:0] exp_wr;

  sramx_memory #(
    .BASE_ADDR (BASE),
    .MEM_WORDS (WORDS)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .ireq     (ireq),
    .iresp    (iresp),
    .dreq     (dreq),
    .dresp    (dresp),
    .bus_err  (bus_err),
    .err_addr (err_addr),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, updating the counter model from the requests presented.
  task automatic cyc();
    if (ireq.en) exp_rd = exp_rd + 32'd1;
    if (dreq.en) begin
      if (dreq.wen == 4'b0000) exp_rd = exp_rd + 32'd1;
      else exp_wr = exp_wr + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ireq = '0;
    dreq = '0;
  endtask

  task automatic dwrite(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    dreq = '{en: 1'b1, wen: w, addr: a, wdata: d};
  endtask

  task automatic dread(input logic [31:0] a);
    dreq = '{en: 1'b1, wen: 4'b0000, addr: a, wdata: 32'h0000_0000};
  endtask

  task automatic iread(input logic [31:0] a);
    ireq = '{en: 1'b1, wen: 4'b1111, addr: a, wdata: 32'hFFFF_FFFF};
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    exp_rd = 32'd0;
    exp_wr = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (3) cyc();
    n_vec++; if (iresp.rdata !== 32'h0) begin n_err++; $display("FAIL reset_irdata got=%h exp=%h", iresp.rdata, 32'h0); end
    n_vec++; if (dresp.rdata !== 32'h0) begin n_err++; $display("FAIL reset_drdata got=%h exp=%h", dresp.rdata, 32'h0); end
    n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL reset_bus_err got=%b exp=0", bus_err); end
    n_vec++; if (err_addr !== 32'h0) begin n_err++; $display("FAIL reset_err_addr got=%h exp=0", err_addr); end
    n_vec++; if (rd_count !== 32'd0) begin n_err++; $display("FAIL reset_rd_count got=%0d exp=0", rd_count); end
    n_vec++; if (wr_count !== 32'd0) begin n_err++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
  endtask

  task automatic test_byte_merge();
    dwrite(BASE + 32'h10, 4'b1111, 32'h1234_5678);
    cyc();
    n_vec++; if (dresp.rdata !== 32'h1234_5678) begin n_err++; $display("FAIL merge_full got=%h exp=%h", dresp.rdata, 32'h1234_5678); end
    dwrite(BASE + 32'h10, 4'b0010, 32'hAAAA_BBBB);
    cyc();
    n_vec++; if (dresp.rdata !== 32'h1234_BB78) begin n_err++; $display("FAIL merge_lane1 got=%h exp=%h", dresp.rdata, 32'h1234_BB78); end
    idle();
    iread(BASE + 32'h13);
    cyc();
    n_vec++; if (iresp.rdata !== 32'h1234_BB78) begin n_err++; $display("FAIL merge_ifetch got=%h exp=%h", iresp.rdata, 32'h1234_BB78); end
    idle();
    n_vec++; if (rd_count !== 32'd1) begin n_err++; $display("FAIL merge_rd_count got=%0d exp=1", rd_count); end
    n_vec++; if (wr_count !== 32'd2) begin n_err++; $display("FAIL merge_wr_count got=%0d exp=2", wr_count); end
  endtask

  task automatic test_collision();
    dwrite(BASE + 32'h40, 4'b1111, 32'hCAFE_F00D);
    iread(BASE + 32'h40);
    cyc();
    idle();
    n_vec++; if (iresp.rdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL coll_irdata got=%h exp=%h", iresp.rdata, 32'hCAFE_F00D); end
    n_vec++; if (dresp.rdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL coll_drdata got=%h exp=%h", dresp.rdata, 32'hCAFE_F00D); end
    n_vec++; if (rd_count !== 32'd2) begin n_err++; $display("FAIL coll_rd_count got=%0d exp=2", rd_count); end
    n_vec++; if (wr_count !== 32'd3) begin n_err++; $display("FAIL coll_wr_count got=%0d exp=3", wr_count); end
  endtask

  task automatic test_hold();
    dwrite(BASE + 32'h20, 4'b1111, 32'h0000_0005);
    cyc();
    dread(BASE + 32'h20);
    iread(BASE + 32'h20);
    cyc();
    idle();
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_vec++; if (iresp.rdata !== 32'h5 || dresp.rdata !== 32'h5) begin n_err++; $display("FAIL hold_%0d got=%h/%h exp=%h", i, iresp.rdata, dresp.rdata, 32'h5); end
      n_vec++; if (rd_count !== exp_rd || wr_count !== exp_wr) begin n_err++; $display("FAIL hold_cnt_%0d got=%0d/%0d exp=%0d/%0d", i, rd_count, wr_count, exp_rd, exp_wr); end
    end
  endtask

  task automatic test_back_to_back();
    dwrite(BASE + 32'h30, 4'b1111, 32'h1111_1111);
    cyc();
    dread(BASE + 32'h30);
    cyc();
    n_vec++; if (dresp.rdata !== 32'h1111_1111) begin n_err++; $display("FAIL b2b_old got=%h exp=%h", dresp.rdata, 32'h1111_1111); end
    dwrite(BASE + 32'h30, 4'b1000, 32'hFF00_0000);
    cyc();
    n_vec++; if (dresp.rdata !== 32'hFF11_1111) begin n_err++; $display("FAIL b2b_write got=%h exp=%h", dresp.rdata, 32'hFF11_1111); end
    dread(BASE + 32'h30);
    cyc();
    idle();
    n_vec++; if (dresp.rdata !== 32'hFF11_1111) begin n_err++; $display("FAIL b2b_new got=%h exp=%h", dresp.rdata, 32'hFF11_1111); end
  endtask

  task automatic test_out_of_range();
    dwrite(BASE + SPANB - 32'd4, 4'b1111, 32'h5A5A_5A5A);
    iread(BASE + 32'h10);
    cyc();
    iread(BASE + SPANB);
    dwrite(BASE - 32'd4, 4'b1111, 32'hFFFF_FFFF);
    cyc();
    idle();
    n_vec++; if (iresp.rdata !== 32'h0) begin n_err++; $display("FAIL oor_irdata got=%h exp=0", iresp.rdata); end
    n_vec++; if (dresp.rdata !== 32'h0) begin n_err++; $display("FAIL oor_drdata got=%h exp=0", dresp.rdata); end
    n_vec++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL oor_bus_err got=%b exp=1", bus_err); end
    n_vec++; if (err_addr !== BASE - 32'd4) begin n_err++; $display("FAIL oor_err_addr got=%h exp=%h", err_addr, BASE - 32'd4); end
    n_vec++; if (rd_count !== exp_rd || wr_count !== exp_wr) begin n_err++; $display("FAIL oor_cnt got=%0d/%0d exp=%0d/%0d", rd_count, wr_count, exp_rd, exp_wr); end
    dread(BASE + SPANB - 32'd4);
    cyc();
    n_vec++; if (dresp.rdata !== 32'h5A5A_5A5A) begin n_err++; $display("FAIL oor_no_write got=%h exp=%h", dresp.rdata, 32'h5A5A_5A5A); end
    dread(BASE + 32'h8000_0000);
    cyc();
    idle();
    n_vec++; if (err_addr !== BASE - 32'd4 || bus_err !== 1'b1) begin n_err++; $display("FAIL oor_sticky got=%h/%b exp=%h/1", err_addr, bus_err, BASE - 32'd4); end
  endtask

  task automatic test_reset_mid();
    dwrite(BASE + 32'h8, 4'b1111, 32'h7654_3210);
    cyc();
    dwrite(BASE + 32'h8, 4'b1111, 32'hDEAD_BEEF);
    #2;
    resetn = 1'b0;
    #1;
    n_vec++; if (dresp.rdata !== 32'h0) begin n_err++; $display("FAIL rstmid_drdata got=%h exp=0", dresp.rdata); end
    n_vec++; if (bus_err !== 1'b0 || err_addr !== 32'h0) begin n_err++; $display("FAIL rstmid_err got=%b/%h exp=0/0", bus_err, err_addr); end
    n_vec++; if (rd_count !== 32'd0 || wr_count !== 32'd0) begin n_err++; $display("FAIL rstmid_cnt got=%0d/%0d exp=0/0", rd_count, wr_count); end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    exp_rd = 32'd0;
    exp_wr = 32'd0;
    dread(BASE + 32'h8);
    cyc();
    idle();
    n_vec++; if (dresp.rdata !== 32'h7654_3210) begin n_err++; $display("FAIL rstmid_retained got=%h exp=%h", dresp.rdata, 32'h7654_3210); end
    n_vec++; if (rd_count !== 32'd1) begin n_err++; $display("FAIL rstmid_first_edge got=%0d exp=1", rd_count); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    resetn = 1'b0;
    idle();
    test_reset();
    test_byte_merge();
    test_collision();
    test_hold();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
